uart_top_core: RTL and testbench

//  8N1 UART with 16x-oversampling baud tick generator, receiver, transmitter and one

---
 rtl/uart_top_core.sv | 308 ++++++++++++++++++++++++++++++
 tb/tb_uart_top_core.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_top_core.sv
// ============================================================================
// Module   : uart_top_core
// Brief    : 8N1 UART with a 16x oversampling tick generator, a receiver, a
//            transmitter and a first-word-fall-through FIFO per direction.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module uart_top_core_fifo #(
  parameter int NB_DATA = 8,
  parameter int NB_ADDR = 4
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               i_wr,
  input  logic [NB_DATA-1:0] i_wdata,
  input  logic               i_rd,
  output logic [NB_DATA-1:0] o_rdata,
  output logic               o_empty,
  output logic               o_full
);
  localparam int               c_DEPTH   = 2**NB_ADDR;
  localparam logic [NB_ADDR-1:0] c_PTR_ONE = {{(NB_ADDR-1){1'b0}}, 1'b1};

  logic [NB_DATA-1:0] r_mem [c_DEPTH];
  logic [NB_ADDR-1:0] r_wr_ptr;
  logic [NB_ADDR-1:0] r_rd_ptr;
  logic               r_empty;
  logic               r_full;
  logic               w_do_wr;
  logic               w_do_rd;
  logic [NB_ADDR-1:0] w_wr_ptr_nxt;
  logic [NB_ADDR-1:0] w_rd_ptr_nxt;

  // A write into a full FIFO is only honoured when a read frees a slot in the same cycle
  assign w_do_wr      = i_wr & (~r_full | i_rd);
  assign w_do_rd      = i_rd & ~r_empty;
  assign w_wr_ptr_nxt = r_wr_ptr + c_PTR_ONE;
  assign w_rd_ptr_nxt = r_rd_ptr + c_PTR_ONE;

  // Storage array, cleared on reset so the head reads zero
  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int i = 0; i < c_DEPTH; i++) r_mem[i] <= '0;
    end else if (w_do_wr) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers and registered occupancy flags
  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
    end else begin
      if (w_do_wr) r_wr_ptr <= w_wr_ptr_nxt;
      if (w_do_rd) r_rd_ptr <= w_rd_ptr_nxt;
      if (w_do_wr && !w_do_rd) begin
        r_empty <= 1'b0;
        r_full  <= (w_wr_ptr_nxt == r_rd_ptr);
      end else if (w_do_rd && !w_do_wr) begin
        r_full  <= 1'b0;
        r_empty <= (w_rd_ptr_nxt == r_wr_ptr);
      end
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_empty = r_empty;
  assign o_full  = r_full;
endmodule

module uart_top_core #(
  parameter int NB_COUNTER   = 9,
  parameter int NB_DATA      = 8,
  parameter int NB_FIFO_ADDR = 4
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic                  i_rx,
  input  logic [NB_COUNTER-1:0] i_tick_cmp,
  input  logic                  i_wr,
  input  logic [NB_DATA-1:0]    i_wdata,
  input  logic                  i_tx_start,
  input  logic                  i_rd,
  output logic                  o_tx,
  output logic                  o_tx_done,
  output logic                  o_tx_empty,
  output logic                  o_tx_full,
  output logic [NB_DATA-1:0]    o_rdata,
  output logic                  o_rx_done,
  output logic                  o_rx_empty,
  output logic                  o_rx_full
);
  localparam int                    c_NB_BITCNT = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;
  localparam logic [c_NB_BITCNT-1:0] c_LAST_BIT  = c_NB_BITCNT'(NB_DATA - 1);
  localparam logic [c_NB_BITCNT-1:0] c_BIT_ONE   = {{(c_NB_BITCNT-1){1'b0}}, 1'b1};
  localparam logic [NB_COUNTER-1:0]  c_CNT_ONE   = {{(NB_COUNTER-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } t_state;

  // ---------------- oversample tick generator ----------------
  logic [NB_COUNTER-1:0] r_tick_cnt;
  logic                  w_tick;

  assign w_tick = (r_tick_cnt == (i_tick_cmp - c_CNT_ONE));

  // Free-running divider, one tick every i_tick_cmp clocks
  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst)      r_tick_cnt <= '0;
    else if (w_tick) r_tick_cnt <= '0;
    else             r_tick_cnt <= r_tick_cnt + c_CNT_ONE;
  end

  // ---------------- receiver ----------------
  logic                   r_rx_meta;
  logic                   r_rx_sync;
  t_state                 r_rx_state;
  logic [3:0]             r_rx_s;
  logic [c_NB_BITCNT-1:0] r_rx_n;
  logic [NB_DATA-1:0]     r_rx_shift;
  logic                   r_rx_done;

  // Two-flop synchroniser on the asynchronous serial input, idles high
  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= i_rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  // Receive FSM: centre on the start bit, then sample every 16 ticks
  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      r_rx_state <= S_IDLE;
      r_rx_s     <= '0;
      r_rx_n     <= '0;
      r_rx_shift <= '0;
      r_rx_done  <= 1'b0;
    end else begin
      r_rx_done <= 1'b0;
      case (r_rx_state)
        S_IDLE: begin
          if (!r_rx_sync) begin
            r_rx_state <= S_START;
            r_rx_s     <= '0;
          end
        end
        S_START: begin
          if (w_tick) begin
            if (r_rx_s == 4'd7) begin
              if (!r_rx_sync) begin
                r_rx_state <= S_DATA;
                r_rx_s     <= '0;
                r_rx_n     <= '0;
              end else begin
                r_rx_state <= S_IDLE;   // low pulse too short: treat as a glitch
              end
            end else begin
              r_rx_s <= r_rx_s + 4'd1;
            end
          end
        end
        S_DATA: begin
          if (w_tick) begin
            if (r_rx_s == 4'd15) begin
              r_rx_s     <= '0;
              r_rx_shift <= {r_rx_sync, r_rx_shift[NB_DATA-1:1]};
              if (r_rx_n == c_LAST_BIT) r_rx_state <= S_STOP;
              else                      r_rx_n     <= r_rx_n + c_BIT_ONE;
            end else begin
              r_rx_s <= r_rx_s + 4'd1;
            end
          end
        end
        S_STOP: begin
          if (w_tick) begin
            if (r_rx_s == 4'd15) begin
              r_rx_state <= S_IDLE;
              r_rx_done  <= 1'b1;
            end else begin
              r_rx_s <= r_rx_s + 4'd1;
            end
          end
        end
        default: r_rx_state <= S_IDLE;
      endcase
    end
  end

  // ---------------- transmitter ----------------
  t_state                 r_tx_state;
  logic [3:0]             r_tx_s;
  logic [c_NB_BITCNT-1:0] r_tx_n;
  logic [NB_DATA-1:0]     r_tx_shift;
  logic                   r_tx;
  logic                   r_tx_done;
  logic                   w_tx_pop;
  logic                   w_tx_empty;
  logic [NB_DATA-1:0]     w_tx_head;

  assign w_tx_pop = (r_tx_state == S_IDLE) && i_tx_start && !w_tx_empty;

  // Transmit FSM with a registered serial output
  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      r_tx_state <= S_IDLE;
      r_tx_s     <= '0;
      r_tx_n     <= '0;
      r_tx_shift <= '0;
      r_tx       <= 1'b1;
      r_tx_done  <= 1'b0;
    end else begin
      r_tx_done <= 1'b0;
      case (r_tx_state)
        S_IDLE: begin
          if (w_tx_pop) begin
            r_tx_state <= S_START;
            r_tx_s     <= '0;
            r_tx_shift <= w_tx_head;
            r_tx       <= 1'b0;
          end
        end
        S_START: begin
          if (w_tick) begin
            if (r_tx_s == 4'd15) begin
              r_tx_state <= S_DATA;
              r_tx_s     <= '0;
              r_tx_n     <= '0;
              r_tx       <= r_tx_shift[0];
            end else begin
              r_tx_s <= r_tx_s + 4'd1;
            end
          end
        end
        S_DATA: begin
          if (w_tick) begin
            if (r_tx_s == 4'd15) begin
              r_tx_s <= '0;
              if (r_tx_n == c_LAST_BIT) begin
                r_tx_state <= S_STOP;
                r_tx       <= 1'b1;
              end else begin
                r_tx_n     <= r_tx_n + c_BIT_ONE;
                r_tx_shift <= r_tx_shift >> 1;
                r_tx       <= r_tx_shift[1];
              end
            end else begin
              r_tx_s <= r_tx_s + 4'd1;
            end
          end
        end
        S_STOP: begin
          if (w_tick) begin
            if (r_tx_s == 4'd15) begin
              r_tx_state <= S_IDLE;
              r_tx_done  <= 1'b1;
            end else begin
              r_tx_s <= r_tx_s + 4'd1;
            end
          end
        end
        default: r_tx_state <= S_IDLE;
      endcase
    end
  end

  // ---------------- FIFOs ----------------
  uart_top_core_fifo #(.NB_DATA(NB_DATA), .NB_ADDR(NB_FIFO_ADDR)) u_tx_fifo (
    .clk     (clk),
    .i_rst   (i_rst),
    .i_wr    (i_wr),
    .i_wdata (i_wdata),
    .i_rd    (w_tx_pop),
    .o_rdata (w_tx_head),
    .o_empty (w_tx_empty),
    .o_full  (o_tx_full)
  );

  uart_top_core_fifo #(.NB_DATA(NB_DATA), .NB_ADDR(NB_FIFO_ADDR)) u_rx_fifo (
    .clk     (clk),
    .i_rst   (i_rst),
    .i_wr    (r_rx_done),
    .i_wdata (r_rx_shift),
    .i_rd    (i_rd),
    .o_rdata (o_rdata),
    .o_empty (o_rx_empty),
    .o_full  (o_rx_full)
  );

  assign o_tx       = r_tx;
  assign o_tx_done  = r_tx_done;
  assign o_tx_empty = w_tx_empty;
  assign o_rx_done  = r_rx_done;
endmodule

`default_nettype wire

// File: tb/tb_uart_top_core.sv
// ============================================================================
// Module   : tb_uart_top_core
// Brief    : Directed self-checking bench for uart_top_core with a second
//            instance acting as the far end of a loopback link.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_top_core;
  localparam int BIT_CLK = 32;      // clocks per bit with tick_cmp = 2
  localparam int BIT_NS  = 320;     // same, in ns at 100 MHz

  logic       clk = 1'b0;
  logic       rst;
  logic       tb_rx;
  logic [8:0] tick_cmp;
  logic       wr;
  logic [7:0] wdata;
  logic       tx_start;
  logic       rd;
  logic       p_rd;

  wire        tx, tx_done, tx_empty, tx_full, rx_done, rx_empty, rx_full;
  wire  [7:0] rdata;
  wire        p_tx, p_tx_done, p_tx_empty, p_tx_full, p_rx_done, p_rx_empty, p_rx_full;
  wire  [7:0] p_rdata;

  int n_tests = 0;
  int n_fail  = 0;
  int rx_done_cnt = 0;
  int tx_done_cnt = 0;
  int p_tx_done_cnt = 0;

  logic [7:0] pat  [20] = '{8'h00, 8'hFE, 8'h1A, 8'h55, 8'hAA, 8'hFF, 8'h01, 8'h80,
                            8'h7F, 8'h3C, 8'hC3, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A,
                            8'hBC, 8'hDE, 8'hF0, 8'h0F};
  logic [7:0] fill [16] = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65, 8'h76, 8'h87,
                            8'h98, 8'hA9, 8'hBA, 8'hCB, 8'hDC, 8'hED, 8'hFE, 8'h0F};

  always #5 clk = ~clk;

  uart_top_core dut (
    .clk(clk), .i_rst(rst), .i_rx(tb_rx), .i_tick_cmp(tick_cmp),
    .i_wr(wr), .i_wdata(wdata), .i_tx_start(tx_start), .i_rd(rd),
    .o_tx(tx), .o_tx_done(tx_done), .o_tx_empty(tx_empty), .o_tx_full(tx_full),
    .o_rdata(rdata), .o_rx_done(rx_done), .o_rx_empty(rx_empty), .o_rx_full(rx_full)
  );

  uart_top_core peer (
    .clk(clk), .i_rst(rst), .i_rx(tx), .i_tick_cmp(tick_cmp),
    .i_wr(1'b0), .i_wdata(8'h00), .i_tx_start(1'b0), .i_rd(p_rd),
    .o_tx(p_tx), .o_tx_done(p_tx_done), .o_tx_empty(p_tx_empty), .o_tx_full(p_tx_full),
    .o_rdata(p_rdata), .o_rx_done(p_rx_done), .o_rx_empty(p_rx_empty), .o_rx_full(p_rx_full)
  );

  // Pulse counters, sampled on the falling edge
  always @(negedge clk) begin
    if (rx_done)   rx_done_cnt++;
    if (tx_done)   tx_done_cnt++;
    if (p_tx_done) p_tx_done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one 8N1 frame onto the DUT serial input
  task automatic send_byte(input logic [7:0] b, input int bit_ns);
    tb_rx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      tb_rx = b[i];
      #(bit_ns);
    end
    tb_rx = 1'b1;
    #(bit_ns);
  endtask

  // Decode one frame from the DUT serial output, sampling mid-bit
  task automatic get_frame(output logic [7:0] b, output logic ok);
    int t;
    t  = 0;
    ok = 1'b0;
    b  = 8'h00;
    do begin
      @(negedge clk);
      t++;
    end while (tx !== 1'b0 && t < 4000);
    if (tx !== 1'b0) return;
    repeat (BIT_CLK/2) @(negedge clk);
    if (tx !== 1'b0) return;
    for (int i = 0; i < 8; i++) begin
      repeat (BIT_CLK) @(negedge clk);
      b[i] = tx;
    end
    repeat (BIT_CLK) @(negedge clk);
    ok = (tx === 1'b1);
  endtask

  initial begin
    logic [7:0] b;
    logic       ok;
    int         base;
    int         sent;
    int         got;
    logic       seen_full;

    rst = 1'b1; tb_rx = 1'b1; tick_cmp = 9'h146;
    wr = 1'b0; wdata = 8'h00; tx_start = 1'b0; rd = 1'b0; p_rd = 1'b0;

    // ---- reset state ----
    #3 rst = 1'b0;
    #1;
    check("rst_tx",       32'(tx),       32'd1);
    check("rst_tx_empty", 32'(tx_empty), 32'd1);
    check("rst_tx_full",  32'(tx_full),  32'd0);
    check("rst_rx_empty", 32'(rx_empty), 32'd1);
    check("rst_rx_full",  32'(rx_full),  32'd0);
    check("rst_tx_done",  32'(tx_done),  32'd0);
    check("rst_rx_done",  32'(rx_done),  32'd0);
    check("rst_rdata",    32'(rdata),    32'h00);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // ---- receive 0x01 at 19200 baud ----
    send_byte(8'h01, 52083);
    @(negedge clk);
    check("rx1_done_cnt", 32'(rx_done_cnt), 32'd1);
    check("rx1_rdata",    32'(rdata),       32'h01);
    check("rx1_empty",    32'(rx_empty),    32'd0);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    check("rx1_pop_empty", 32'(rx_empty), 32'd1);

    // Faster divisor for the rest; let the divider wrap to the new compare value
    tick_cmp = 9'd2;
    repeat (600) @(negedge clk);

    // ---- transmit 0x13, 0xA5 ----
    base = tx_done_cnt;
    wr = 1'b1; wdata = 8'h13;
    @(negedge clk);
    wdata = 8'hA5;
    @(negedge clk);
    wr = 1'b0;
    check("tx_not_empty", 32'(tx_empty), 32'd0);
    check("tx_idle_high", 32'(tx),       32'd1);
    tx_start = 1'b1;
    get_frame(b, ok);
    check("tx0_frame", 32'(ok), 32'd1);
    check("tx0_data",  32'(b),  32'h13);
    get_frame(b, ok);
    check("tx1_frame", 32'(ok), 32'd1);
    check("tx1_data",  32'(b),  32'hA5);
    tx_start = 1'b0;
    repeat (40) @(negedge clk);
    check("tx_done_cnt", 32'(tx_done_cnt - base), 32'd2);
    check("tx_empty",    32'(tx_empty),           32'd1);
    check("tx_end_high", 32'(tx),                 32'd1);

    // The peer saw both frames too
    check("peer_nonempty", 32'(p_rx_empty), 32'd0);
    check("peer_b0", 32'(p_rdata), 32'h13);
    p_rd = 1'b1;
    @(negedge clk);
    p_rd = 1'b0;
    check("peer_b1", 32'(p_rdata), 32'hA5);
    p_rd = 1'b1;
    @(negedge clk);
    p_rd = 1'b0;
    check("peer_empty", 32'(p_rx_empty), 32'd1);

    // ---- loopback of 20 bytes into the peer ----
    sent = 0; got = 0; seen_full = 1'b0;
    tx_start = 1'b1;
    for (int t = 0; t < 20000 && got < 20; t++) begin
      @(negedge clk);
      wr = 1'b0;
      p_rd = 1'b0;
      if (tx_full) seen_full = 1'b1;
      if (sent < 20 && !tx_full) begin
        wr = 1'b1;
        wdata = pat[sent];
        sent++;
      end
      if (!p_rx_empty) begin
        check("loop_byte", 32'(p_rdata), 32'(pat[got]));
        p_rd = 1'b1;
        got++;
      end
    end
    @(negedge clk);
    wr = 1'b0; p_rd = 1'b0; tx_start = 1'b0;
    check("loop_count",     32'(got),        32'd20);
    check("loop_seen_full", 32'(seen_full),  32'd1);
    check("peer_rx_full",   32'(p_rx_full),  32'd0);
    check("peer_tx_idle",   32'(p_tx),       32'd1);
    check("peer_tx_empty",  32'(p_tx_empty), 32'd1);
    check("peer_tx_full",   32'(p_tx_full),  32'd0);
    check("peer_tx_done",   32'(p_tx_done_cnt), 32'd0);
    check("peer_rx_done",   32'(p_rx_done),  32'd0);

    // ---- fill RX FIFO, overflow byte dropped ----
    for (int i = 0; i < 16; i++) send_byte(fill[i], BIT_NS);
    @(negedge clk);
    check("fill_full", 32'(rx_full), 32'd1);
    base = rx_done_cnt;
    send_byte(8'h77, BIT_NS);
    @(negedge clk);
    check("ovf_done_pulse", 32'(rx_done_cnt - base), 32'd1);
    check("ovf_still_full", 32'(rx_full),            32'd1);
    for (int i = 0; i < 16; i++) begin
      check("fill_pop", 32'(rdata), 32'(fill[i]));
      rd = 1'b1;
      @(negedge clk);
      rd = 1'b0;
    end
    check("fill_drained", 32'(rx_empty), 32'd1);
    check("fill_not_full", 32'(rx_full), 32'd0);

    // ---- start-bit glitch of 3 ticks ----
    base = rx_done_cnt;
    tb_rx = 1'b0;
    repeat (6) @(negedge clk);
    tb_rx = 1'b1;
    repeat (400) @(negedge clk);
    check("glitch_no_done", 32'(rx_done_cnt - base), 32'd0);
    check("glitch_empty",   32'(rx_empty),           32'd1);
    send_byte(8'h5A, BIT_NS);
    @(negedge clk);
    check("post_glitch_done", 32'(rx_done_cnt - base), 32'd1);
    check("post_glitch_data", 32'(rdata),              32'h5A);

    // ---- reset in the middle of a transmitted frame ----
    wr = 1'b1; wdata = 8'h00;
    @(negedge clk);
    wr = 1'b0;
    tx_start = 1'b1;
    repeat (100) @(negedge clk);
    check("mid_frame_low", 32'(tx), 32'd0);
    #2 rst = 1'b0;
    #1;
    check("abort_tx_high",  32'(tx),       32'd1);
    check("abort_tx_empty", 32'(tx_empty), 32'd1);
    check("abort_rx_empty", 32'(rx_empty), 32'd1);
    check("abort_rdata",    32'(rdata),    32'h00);
    tx_start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
